hsem_lock_master: RTL and testbench

Per-core AHB initiator that acquires and releases HSEM semaphores on behalf of a local hardware agent. It sits between one core-side request port and the AHB bus, and drives the HSEM register block at its resource offsets 0x00–0x1C.
- Lock: write {CORE_ID, lock=1}, read the register back and check ownership.
- Busy: back off and retry a bounded number of times.
- Unlock: single write.
- Result is returned on a valid/ready response port.

---
 rtl/hsem_pkg.sv | 39 +++
 rtl/hsem_backoff_cnt.sv | 38 +++
 rtl/hsem_lock_master.sv | 180 ++++++++++++++++++
 tb/tb_hsem_lock_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsem_pkg.sv
// Shared definitions for the HSEM lock initiator: register offsets, status
// codes, AHB constants, FSM states and the well-known core IDs.
package hsem_pkg;

  // Owner IDs of the two cores sharing the semaphore block.
  localparam logic [7:0] CORE_0_ID = 8'h01;
  localparam logic [7:0] CORE_1_ID = 8'h02;

  // HSEM resource registers sit on consecutive words: R0 at 0x00 .. R7 at 0x1C.
  localparam int HSEM_NUM_RES = 8;

  function automatic logic [4:0] hsem_res_ofs(input logic [2:0] sem);
    return {sem, 2'b00};
  endfunction

  // AHB-Lite encodings used by this initiator (single word transfers only).
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Result codes returned on the response port.
  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_BUSY    = 2'b01,
    STATUS_BUS_ERR = 2'b10
  } status_e;

  // Lock/unlock sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_D,
    S_RD_A,
    S_RD_D,
    S_BACKOFF,
    S_RSP
  } state_e;

endpackage

// File: rtl/hsem_backoff_cnt.sv
// Loadable down-counter with a zero flag; serves both as the retry budget
// and as the inter-attempt idle timer.
module hsem_backoff_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/hsem_lock_master.sv
// Per-core AHB initiator that takes or frees an HSEM semaphore for a local
// agent: lock = write then read-back ownership check with bounded retries,
// unlock = single write. One request in flight; result on a valid/ready port.
module hsem_lock_master
  import hsem_pkg::*;
#(
  parameter logic [7:0]  CORE_ID   = CORE_0_ID,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 4,
  parameter int          BACKOFF   = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [2:0]  req_sem,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(BACKOFF + 1);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] addr_q, addr_d;
  status_e     status_q, status_d;

  logic retry_load, retry_dec, retry_done;
  logic bo_load, bo_dec, bo_done;
  logic granted;

  // Only the lock bit and owner field of the read-back matter.
  logic unused_hrdata;
  assign unused_hrdata = ^{hrdata[31:16], hrdata[7:1]};

  assign granted    = hrdata[0] && (hrdata[15:8] == CORE_ID);
  assign hsize      = HSIZE_WORD;
  assign rsp_status = status_q;

  // Remaining lock attempts after the current one.
  hsem_backoff_cnt #(.WIDTH(RW)) u_retry_cnt (
    .clk      (hclk),
    .rst_n    (hresetn),
    .load     (retry_load),
    .load_val (RW'(MAX_RETRY - 1)),
    .dec      (retry_dec),
    .done     (retry_done)
  );

  // Idle gap between a refused read-back and the next write attempt.
  hsem_backoff_cnt #(.WIDTH(BW)) u_backoff_cnt (
    .clk      (hclk),
    .rst_n    (hresetn),
    .load     (bo_load),
    .load_val (BW'(BACKOFF - 1)),
    .dec      (bo_dec),
    .done     (bo_done)
  );

  // Next-state, captured request and bus/response outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    status_d   = status_q;
    retry_load = 1'b0;
    retry_dec  = 1'b0;
    bo_load    = 1'b0;
    bo_dec     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    htrans     = HTRANS_IDLE;
    hwrite     = 1'b0;
    haddr      = '0;
    hwdata     = '0;

    case (state_q)
      S_IDLE: begin
        // Gated by reset so the port reads not-ready while held in reset.
        req_ready = hresetn;
        if (req_valid) begin
          state_d    = S_WR_A;
          op_d       = req_op;
          addr_d     = BASE_ADDR + {27'd0, hsem_res_ofs(req_sem)};
          retry_load = 1'b1;
        end
      end

      S_WR_A: begin
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = addr_q;
        if (hready) state_d = S_WR_D;
      end

      S_WR_D: begin
        // Lock bit is the inverse of the op: 0 = lock writes 1.
        hwdata = {16'h0, CORE_ID, 7'h0, ~op_q};
        if (hready) begin
          if (hresp) begin
            status_d = STATUS_BUS_ERR;
            state_d  = S_RSP;
          end else if (op_q) begin
            status_d = STATUS_OK;
            state_d  = S_RSP;
          end else begin
            state_d = S_RD_A;
          end
        end
      end

      S_RD_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = addr_q;
        if (hready) state_d = S_RD_D;
      end

      S_RD_D: begin
        if (hready) begin
          if (hresp) begin
            status_d = STATUS_BUS_ERR;
            state_d  = S_RSP;
          end else if (granted) begin
            status_d = STATUS_OK;
            state_d  = S_RSP;
          end else if (retry_done) begin
            status_d = STATUS_BUSY;
            state_d  = S_RSP;
          end else begin
            retry_dec = 1'b1;
            bo_load   = 1'b1;
            state_d   = S_BACKOFF;
          end
        end
      end

      S_BACKOFF: begin
        if (bo_done) begin
          state_d = S_WR_A;
        end else begin
          bo_dec = 1'b1;
        end
      end

      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      status_q <= STATUS_OK;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_hsem_lock_master.sv
`timescale 1ns/1ps
module tb_hsem_lock_master;
  import hsem_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [2:0]  req_sem = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_status;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } xfer_t;
  typedef struct { int waits; logic err; logic [31:0] rdata; } reply_t;
  typedef struct { logic [1:0] status; int lat; } rsp_t;

  xfer_t  exp_xfer_q[$];
  reply_t reply_q[$];
  rsp_t   exp_rsp_q[$];

  localparam logic [31:0] LOCK_WD   = 32'h0000_0101;
  localparam logic [31:0] UNLOCK_WD = 32'h0000_0100;
  localparam logic [31:0] OTHER_RD  = {16'h0, CORE_1_ID, 7'h0, 1'b1};

  always #5 hclk = ~hclk;

  hsem_lock_master #(
    .CORE_ID   (8'h01),
    .BASE_ADDR (32'h0000_0000),
    .MAX_RETRY (4),
    .BACKOFF   (8)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_sem    (req_sem),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp)
  );

  // AHB slave: checks each address phase against the expected-transfer queue
  // and plays back the queued reply (wait states, error, read data).
  initial begin : ahb_slave
    xfer_t       ex;
    reply_t      rp;
    logic        is_wr;
    logic [31:0] wd;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    forever begin
      @(negedge hclk);
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      if (hresetn && htrans == HTRANS_NONSEQ) begin
        n_checks++;
        is_wr = hwrite;
        wd    = '0;
        if (exp_xfer_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_xfer: haddr=%h hwrite=%b, required no transfer", haddr, hwrite);
        end else begin
          ex = exp_xfer_q.pop_front();
          if (haddr !== ex.addr || hwrite !== ex.wr || hsize !== HSIZE_WORD) begin
            n_errors++;
            $display("FAIL addr_phase: haddr=%h hwrite=%b hsize=%b, required haddr=%h hwrite=%b hsize=010",
                     haddr, hwrite, hsize, ex.addr, ex.wr);
          end
          is_wr = ex.wr;
          wd    = ex.wdata;
        end
        if (reply_q.size() > 0) rp = reply_q.pop_front();
        else rp = '{0, 1'b0, 32'h0};
        for (int w = 0; w <= rp.waits; w++) begin
          @(negedge hclk);
          if (w == rp.waits) begin
            hready = 1'b1; hresp = rp.err; hrdata = rp.rdata;
          end else begin
            hready = 1'b0; hresp = 1'b0; hrdata = '0;
          end
          if (hresetn) begin
            n_checks++;
            if (htrans !== HTRANS_IDLE || (is_wr && hwdata !== wd)) begin
              n_errors++;
              $display("FAIL data_phase: htrans=%b hwdata=%h, required htrans=00 hwdata=%h", htrans, hwdata, wd);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic op, input logic [2:0] sem);
    int n;
    n = 0;
    @(negedge hclk);
    req_valid = 1'b1; req_op = op; req_sem = sem;
    while (!req_ready && n < 50) begin
      @(negedge hclk);
      n++;
    end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL req_accept: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    @(posedge hclk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int lat, output bit to);
    lat = 0;
    do begin
      @(negedge hclk);
      lat++;
    end while (!rsp_valid && lat < max);
    to = !rsp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge hclk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_status !== 2'b00 || htrans !== 2'b00 ||
        hwrite !== 1'b0 || haddr !== 32'h0 || hwdata !== 32'h0 || hsize !== 3'b010) begin
      n_errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b st=%b htrans=%b hwrite=%b haddr=%h hwdata=%h hsize=%b, required 0 0 00 00 0 0 0 010",
               req_ready, rsp_valid, rsp_status, htrans, hwrite, haddr, hwdata, hsize);
    end
    hresetn = 1'b1;
    @(negedge hclk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_lock_ok();
    rsp_t ex; int lat; bit to;
    exp_xfer_q.push_back('{32'h0C, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_xfer_q.push_back('{32'h0C, 1'b0, 32'h0});   reply_q.push_back('{0, 1'b0, LOCK_WD});
    exp_rsp_q.push_back('{STATUS_OK, 5});
    send_req(1'b0, 3'd3);
    wait_rsp(100, lat, to);
    ex = exp_rsp_q.pop_front();
    n_checks++;
    if (to || rsp_status !== ex.status || lat != ex.lat) begin
      n_errors++;
      $display("FAIL lock_ok: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d", rsp_status, lat, to, ex.status, ex.lat);
    end
    @(negedge hclk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_ok_done: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_busy();
    rsp_t ex; int lat; bit to;
    for (int k = 0; k < 4; k++) begin
      exp_xfer_q.push_back('{32'h08, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
      exp_xfer_q.push_back('{32'h08, 1'b0, 32'h0});   reply_q.push_back('{0, 1'b0, OTHER_RD});
    end
    // 4 attempts of 4 cycles, 3 gaps of 8, response one cycle after last read.
    exp_rsp_q.push_back('{STATUS_BUSY, 41});
    send_req(1'b0, 3'd2);
    wait_rsp(200, lat, to);
    ex = exp_rsp_q.pop_front();
    n_checks++;
    if (to || rsp_status !== ex.status || lat != ex.lat) begin
      n_errors++;
      $display("FAIL busy: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d", rsp_status, lat, to, ex.status, ex.lat);
    end
    @(negedge hclk);
  endtask

  task automatic test_ownership();
    rsp_t ex; int lat; bit to;
    exp_xfer_q.push_back('{32'h14, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_xfer_q.push_back('{32'h14, 1'b0, 32'h0});   reply_q.push_back('{0, 1'b0, 32'h0000_0200});
    exp_xfer_q.push_back('{32'h14, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_xfer_q.push_back('{32'h14, 1'b0, 32'h0});   reply_q.push_back('{0, 1'b0, LOCK_WD});
    exp_rsp_q.push_back('{STATUS_OK, 17});
    send_req(1'b0, 3'd5);
    wait_rsp(100, lat, to);
    ex = exp_rsp_q.pop_front();
    n_checks++;
    if (to || rsp_status !== ex.status || lat != ex.lat) begin
      n_errors++;
      $display("FAIL ownership: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d", rsp_status, lat, to, ex.status, ex.lat);
    end
    @(negedge hclk);
  endtask

  task automatic test_unlock_wait();
    rsp_t ex; int lat; bit to;
    exp_xfer_q.push_back('{32'h1C, 1'b1, UNLOCK_WD}); reply_q.push_back('{2, 1'b0, 32'h0});
    exp_rsp_q.push_back('{STATUS_OK, 5});
    send_req(1'b1, 3'd7);
    wait_rsp(100, lat, to);
    ex = exp_rsp_q.pop_front();
    n_checks++;
    if (to || rsp_status !== ex.status || lat != ex.lat) begin
      n_errors++;
      $display("FAIL unlock_wait: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d", rsp_status, lat, to, ex.status, ex.lat);
    end
    @(negedge hclk);
  endtask

  task automatic test_bus_err_hold();
    rsp_t ex; int lat; bit to;
    exp_xfer_q.push_back('{32'h04, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_xfer_q.push_back('{32'h04, 1'b0, 32'h0});   reply_q.push_back('{0, 1'b1, LOCK_WD});
    exp_rsp_q.push_back('{STATUS_BUS_ERR, 5});
    rsp_ready = 1'b0;
    send_req(1'b0, 3'd1);
    wait_rsp(100, lat, to);
    ex = exp_rsp_q.pop_front();
    n_checks++;
    if (to || rsp_status !== ex.status || lat != ex.lat) begin
      n_errors++;
      $display("FAIL bus_err: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d", rsp_status, lat, to, ex.status, ex.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== ex.status) begin
        n_errors++;
        $display("FAIL bus_err_hold[%0d]: rsp_valid=%b status=%b, required 1 %b", i, rsp_valid, rsp_status, ex.status);
      end
    end
    rsp_ready = 1'b1;
    @(negedge hclk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bus_err_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_xfer_q.push_back('{32'h10, 1'b1, LOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_xfer_q.push_back('{32'h10, 1'b0, 32'h0});   reply_q.push_back('{6, 1'b0, LOCK_WD});
    send_req(1'b0, 3'd4);
    repeat (5) @(negedge hclk);   // fifth cycle: read data phase stalled
    hresetn = 1'b0;
    #1;
    n_checks++;
    if (htrans !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || hwrite !== 1'b0 || haddr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid: htrans=%b rsp_valid=%b req_ready=%b hwrite=%b haddr=%h, required 00 0 0 0 0",
               htrans, rsp_valid, req_ready, hwrite, haddr);
    end
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_ready: req_ready=%b, required 1", req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge hclk);
      n_checks++;
      if (rsp_valid !== 1'b0 || htrans !== HTRANS_IDLE) begin
        n_errors++;
        $display("FAIL reset_mid_quiet[%0d]: rsp_valid=%b htrans=%b, required 0 00", i, rsp_valid, htrans);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t ex; int lat; bit to;
    exp_xfer_q.push_back('{32'h00, 1'b1, UNLOCK_WD}); reply_q.push_back('{0, 1'b0, 32'h0});
    exp_rsp_q.push_back('{STATUS_OK, 3});
    exp_xfer_q.push_back('{32'h18, 1'b1, LOCK_WD});   reply_q.push_back('{0, 1'b1, 32'h0});
    exp_rsp_q.push_back('{STATUS_BUS_ERR, 3});
    for (int r = 0; r < 2; r++) begin
      send_req(r == 0 ? 1'b1 : 1'b0, r == 0 ? 3'd0 : 3'd6);
      wait_rsp(100, lat, to);
      ex = exp_rsp_q.pop_front();
      n_checks++;
      if (to || rsp_status !== ex.status || lat != ex.lat) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: status=%b lat=%0d timeout=%0b, required status=%b lat=%0d",
                 r, rsp_status, lat, to, ex.status, ex.lat);
      end
    end
    @(negedge hclk);
  endtask

  initial begin : main
    test_reset();
    test_lock_ok();
    test_busy();
    test_ownership();
    test_unlock_wait();
    test_bus_err_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge hclk);
    n_checks++;
    if (exp_xfer_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_xfers: %0d pending, required 0", exp_xfer_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
